ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage RV32IM pipeline. It consumes the ID/EX operands and the forward_a/forward_b selects from the forwarding unit, and applies the operand bypass muxes. It computes the ALU, multiply or iterative-divide result and holds the EX/MEM pipeline register. Its registered rd_mem/RegWrite_mem outputs feed the forwarding unit. The MEM-path bypass value is this block's own EX/MEM result register.

## Interface
- XLEN, 32, datapath width; divider iteration count equals XLEN
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_ex  in  1  ID/EX holds a live instruction
- rs1_val_ex, rs2_val_ex  in  XLEN  register-file operands
- imm_ex  in  XLEN  sign-extended immediate
- alu_op_ex  in  5  operation code (isa.v)
- alu_src_b_ex  in  1  1 selects imm_ex as operand B; the store data path still uses forwarded rs2
- rd_ex  in  5  destination register
- RegWrite_ex, MemRead_ex, MemWrite_ex  in  1  control bits carried to MEM
- forward_a, forward_b  in  2  00 register file, 01 wb_data, 10 alu_result_mem, 11 treated as 00
- wb_data  in  XLEN  WB-stage writeback value
- flush_ex  in  1  kill the instruction in EX
- stall_ex  out  1  hold PC, IF/ID and ID/EX (combinational)
- valid_mem  out  1  EX/MEM valid
- alu_result_mem  out  XLEN  EX/MEM result, also the MEM bypass source
- store_data_mem  out  XLEN  forwarded rs2 value
- rd_mem  out  5  EX/MEM destination
- RegWrite_mem, MemRead_mem, MemWrite_mem  out  1  control bits, each gated by valid

## Operation
- Operand A = mux(forward_a). Forwarded B = mux(forward_b). Operand B = alu_src_b_ex ? imm_ex : forwarded B.
- ALU ops:
  - ADD, SUB, AND, OR, XOR, SLT, SLTU
  - SLL, SRL, SRA: shift amount is B[4:0]
  - LUI: passes B
- Multiply ops, single cycle:
  - MUL returns product bits [31:0].
  - MULH, MULHSU, MULHU return bits [63:32] of the 64-bit signed×signed, signed×unsigned and unsigned×unsigned products respectively.
- Divide ops DIV, DIVU, REM, REMU use a radix-2 restoring divider. It runs on magnitudes, with sign fixup at completion.
- Divide FSM states: IDLE, BUSY, DONE.
  - IDLE, valid_ex with a divide op, no flush: latch forwarded A/B and the op. Go to BUSY with count = 0 and stall_ex = 1. Latching is required because the forwarding sources move while EX is stalled.
  - IDLE, divide by zero or signed overflow (-2^31 / -1): latch the special result and go directly to DONE. stall_ex = 1 for this one cycle.
  - BUSY: one quotient bit per cycle, stall_ex = 1. When count = XLEN-1, go to DONE.
  - DONE: stall_ex = 0. The divide result is selected into EX/MEM at the next edge, then return to IDLE.
- Special results:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- EX/MEM update at each edge:
  - flush_ex or stall_ex: load a bubble. valid_mem = 0 and all control outputs = 0. Data fields are don't-care and hold their previous value.
  - Otherwise: capture the result, the forwarded B value, rd and controls, with valid_mem = valid_ex.
- flush_ex in any state returns the FSM to IDLE at the next edge and drops stall_ex in the same cycle, which aborts the divide. flush_ex has priority over a new divide issue.
- A non-divide instruction never asserts stall_ex.

## Timing
- ALU and multiply: 1-cycle latency. The result is visible on alu_result_mem the cycle after EX, so back-to-back dependents forward with no bubble.
- Normal divide: stall_ex is high for XLEN+1 = 33 consecutive cycles (issue cycle plus 32 BUSY cycles). The DONE cycle follows, and the result appears in EX/MEM one cycle after DONE. Issue-to-result is 35 cycles.
- Special-case divide: stall_ex is high for 1 cycle. The result is registered at the end of the DONE cycle, the cycle after issue.
- During a stall, instructions already in MEM and WB still retire. Bubbles drive RegWrite_mem = 0 so the forwarding unit sees no false match.
- Reset (asynchronous, rst_n low) sets:
  - valid_mem, RegWrite_mem, MemRead_mem, MemWrite_mem, stall_ex = 0
  - alu_result_mem, store_data_mem = 0; rd_mem = 0
  - FSM = IDLE, count = 0
- Reset mid-divide discards the operation.

## Structure
- isa.v holds the ALU op codes and the forward-select constants FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
- Sub-module div_iter holds the divider datapath, counter and sign fixup, with a start/abort/done interface. The FSM, the bypass muxes, the ALU/multiply and the EX/MEM register stay in ex_stage.

## Test plan
- ADD with forward_a = 10, previous result 0x00000005, rs2 = 3: alu_result_mem = 8 next cycle, RegWrite_mem = 1.
- SUB with forward_b = 01, wb_data = 0x10, A = 0x30: result 0x20. With forward_b = 11 and rs2_val_ex = 1: result 0x2F.
- DIV -7/2: stall_ex high for exactly 33 cycles, then valid_mem = 1 with 0xFFFFFFFD. REM of the same operands gives 0xFFFFFFFF. wb_data changes mid-divide do not affect the result.
- DIVU x/0 gives 0xFFFFFFFF. DIV 0x80000000/-1 gives 0x80000000. Each stalls 1 cycle only.
- flush_ex asserted in BUSY cycle 10: stall_ex drops in the same cycle, valid_mem = 0 next edge, and the next ADD completes in 1 cycle.
- rst_n pulsed low mid-divide: all outputs 0 immediately and the FSM returns to IDLE. MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32IM execute stage: operation codes, forward
// selects, divider FSM states and small decode helpers.
package ex_stage_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_LUI    = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider on operand magnitudes with sign fixup and
// special-case results (divide by zero, signed overflow).
module div_iter
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_rem,
  output logic            special,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, spec_val_q;
  logic [CNT_W-1:0] count_q;
  logic             neg_q, neg_r, rem_sel_q, spec_q;

  logic             div_zero, overflow;
  logic [XLEN-1:0]  dvd_mag, dvs_mag, spec_val;
  logic [XLEN:0]    shifted, trial;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == INT_MIN) && (divisor == '1);
  assign special  = div_zero || overflow;

  assign spec_val = div_zero ? (is_rem ? dividend : '1)
                             : (is_rem ? '0 : INT_MIN);

  assign dvd_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only when it does not go negative.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  assign done = step && (count_q == CNT_W'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      spec_val_q <= '0;
      count_q    <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem_sel_q  <= 1'b0;
      spec_q     <= 1'b0;
    end else if (abort) begin
      count_q <= '0;
      spec_q  <= 1'b0;
    end else if (start) begin
      rem_q      <= '0;
      quo_q      <= dvd_mag;
      dvsr_q     <= dvs_mag;
      spec_val_q <= spec_val;
      count_q    <= '0;
      neg_q      <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r      <= is_signed && dividend[XLEN-1];
      rem_sel_q  <= is_rem;
      spec_q     <= special;
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      count_q <= count_q + 1'b1;
    end
  end

  assign quo_fix = neg_q ? -quo_q : quo_q;
  assign rem_fix = neg_r ? -rem_q : rem_q;
  assign result  = spec_q ? spec_val_q : (rem_sel_q ? rem_fix : quo_fix);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand bypass muxes, ALU/multiply, divide control
// FSM around div_iter, and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] rs1_val_ex,
  input  logic [XLEN-1:0] rs2_val_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [4:0]      alu_op_ex,
  input  logic            alu_src_b_ex,
  input  logic [4:0]      rd_ex,
  input  logic            RegWrite_ex,
  input  logic            MemRead_ex,
  input  logic            MemWrite_ex,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush_ex,
  output logic            stall_ex,
  output logic            valid_mem,
  output logic [XLEN-1:0] alu_result_mem,
  output logic [XLEN-1:0] store_data_mem,
  output logic [4:0]      rd_mem,
  output logic            RegWrite_mem,
  output logic            MemRead_mem,
  output logic            MemWrite_mem,
  output div_state_e      div_state
);

  logic [XLEN-1:0]   op_a, fwd_b, op_b, exec_result, div_result;
  logic [CNT_W-1:0]  shamt;
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              div_issue, div_start, div_step, div_abort, div_special, div_done;
  div_state_e        state_q, state_d;

  always_comb begin
    case (forward_a)
      FWD_WB:  op_a = wb_data;
      FWD_MEM: op_a = alu_result_mem;
      default: op_a = rs1_val_ex;
    endcase
    case (forward_b)
      FWD_WB:  fwd_b = wb_data;
      FWD_MEM: fwd_b = alu_result_mem;
      default: fwd_b = rs2_val_ex;
    endcase
  end

  assign op_b  = alu_src_b_ex ? imm_ex : fwd_b;
  assign shamt = op_b[CNT_W-1:0];

  // A single double-width multiplier; operand extension picks the signedness.
  assign mul_a_signed = (alu_op_ex == OP_MULH) || (alu_op_ex == OP_MULHSU);
  assign mul_b_signed = (alu_op_ex == OP_MULH);
  assign mul_a = {{XLEN{mul_a_signed & op_a[XLEN-1]}}, op_a};
  assign mul_b = {{XLEN{mul_b_signed & op_b[XLEN-1]}}, op_b};
  assign prod  = mul_a * mul_b;

  always_comb begin
    exec_result = '0;
    case (alu_op_ex)
      OP_ADD:    exec_result = op_a + op_b;
      OP_SUB:    exec_result = op_a - op_b;
      OP_AND:    exec_result = op_a & op_b;
      OP_OR:     exec_result = op_a | op_b;
      OP_XOR:    exec_result = op_a ^ op_b;
      OP_SLT:    exec_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   exec_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_SLL:    exec_result = op_a << shamt;
      OP_SRL:    exec_result = op_a >> shamt;
      OP_SRA:    exec_result = $signed(op_a) >>> shamt;
      OP_LUI:    exec_result = op_b;
      OP_MUL:    exec_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: exec_result = prod[2*XLEN-1:XLEN];
      default:   exec_result = '0;
    endcase
  end

  assign div_issue = valid_ex && is_div_op(alu_op_ex);

  div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .step      (div_step),
    .abort     (div_abort),
    .dividend  (op_a),
    .divisor   (op_b),
    .is_signed (is_signed_div(alu_op_ex)),
    .is_rem    (is_rem_op(alu_op_ex)),
    .special   (div_special),
    .done      (div_done),
    .result    (div_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // stall_ex high means ID/EX must hold; the held divide retires in DONE.
  always_comb begin
    state_d   = state_q;
    stall_ex  = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    div_abort = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (!flush_ex && div_issue) begin
          div_start = 1'b1;
          stall_ex  = 1'b1;
          state_d   = div_special ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (flush_ex) begin
          div_abort = 1'b1;
          state_d   = DIV_IDLE;
        end else begin
          div_step = 1'b1;
          stall_ex = 1'b1;
          if (div_done) state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign div_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem      <= 1'b0;
      alu_result_mem <= '0;
      store_data_mem <= '0;
      rd_mem         <= '0;
      RegWrite_mem   <= 1'b0;
      MemRead_mem    <= 1'b0;
      MemWrite_mem   <= 1'b0;
    end else if (flush_ex || stall_ex) begin
      valid_mem    <= 1'b0;
      RegWrite_mem <= 1'b0;
      MemRead_mem  <= 1'b0;
      MemWrite_mem <= 1'b0;
    end else begin
      valid_mem      <= valid_ex;
      alu_result_mem <= (state_q == DIV_DONE) ? div_result : exec_result;
      store_data_mem <= fwd_b;
      rd_mem         <= rd_ex;
      RegWrite_mem   <= valid_ex && RegWrite_ex;
      MemRead_mem    <= valid_ex && MemRead_ex;
      MemWrite_mem   <= valid_ex && MemWrite_ex;
    end
  end

endmodule
